// File: rtl/sfp_feeder.sv
// sfp_feeder: reads partial sums out of the psum memory in kij-major order
// and streams them into the SFP accumulator. Each output pixel's kernel
// positions go out back to back. The first kij of a pixel restarts
// accumulation, and the last kij may apply ReLU.
//
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   start         - begin one pass (sampled in IDLE only)
//   relu_mode     - apply ReLU on the final kij (latched with start)
//   hold          - stall read issue for this cycle
//   mem_rd_en     - psum memory read strobe
//   mem_addr      - psum memory read address (k*num_o + o)
//   mem_rdata     - read data, valid one cycle after mem_rd_en
//   sfp_in        - data to the SFP (pass-through of mem_rdata)
//   sfp_valid     - SFP valid_in
//   sfp_acc_en    - SFP accumulate enable
//   sfp_relu_en   - SFP ReLU enable
//   final_valid   - SFP output holds a finished pixel this cycle
//   final_addr    - index of that pixel
//   busy          - pass in progress
//   done          - one-cycle pass-complete pulse
module sfp_feeder #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned num_o   = 16,
  parameter int unsigned num_kij = 9,
  parameter int unsigned addr_bw = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       relu_mode,
  input  logic                       hold,
  output logic                       mem_rd_en,
  output logic [addr_bw-1:0]         mem_addr,
  input  logic [psum_bw*col-1:0]     mem_rdata,
  output logic [psum_bw*col-1:0]     sfp_in,
  output logic                       sfp_valid,
  output logic                       sfp_acc_en,
  output logic                       sfp_relu_en,
  output logic                       final_valid,
  output logic [addr_bw-1:0]         final_addr,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned O_W = (num_o > 1) ? $clog2(num_o) : 1;
  localparam int unsigned K_W = (num_kij > 1) ? $clog2(num_kij) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [O_W-1:0]     r_o;
  logic [K_W-1:0]     r_k;
  logic [addr_bw-1:0] r_addr;
  logic               r_relu_mode;
  logic               r_drain_cnt;

  logic               r_s1_valid;
  logic               r_s1_acc;
  logic               r_s1_relu;
  logic               r_s1_last;
  logic [O_W-1:0]     r_s1_o;
  logic               r_final_valid;
  logic [addr_bw-1:0] r_final_addr;

  logic               w_issue;
  logic               w_k_last;
  logic               w_o_last;

  assign w_k_last = (r_k == K_W'(num_kij - 1));
  assign w_o_last = (r_o == O_W'(num_o - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and read issue.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_issue = !hold;
        if (w_issue && w_k_last && w_o_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Two cycles: lets the last beat reach the SFP and its result appear.
        if (r_drain_cnt) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pixel/kij counters and the running address k*num_o + o.
  // The address steps by num_o along k. It restarts at o+1 when k wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_o         <= '0;
      r_k         <= '0;
      r_addr      <= '0;
      r_relu_mode <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_o         <= '0;
            r_k         <= '0;
            r_addr      <= '0;
            r_relu_mode <= relu_mode;
          end
        end
        S_READ: begin
          if (w_issue) begin
            if (w_k_last) begin
              r_k <= '0;
              if (w_o_last) begin
                r_o    <= '0;
                r_addr <= '0;
              end else begin
                r_o    <= r_o + O_W'(1);
                r_addr <= addr_bw'(r_o) + addr_bw'(1);
              end
            end else begin
              r_k    <= r_k + K_W'(1);
              r_addr <= r_addr + addr_bw'(num_o);
            end
          end
        end
        default: begin
          r_o    <= '0;
          r_k    <= '0;
          r_addr <= '0;
        end
      endcase
    end
  end

  // Drain cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drain_cnt <= 1'b0;
    end else if (r_state == S_DRAIN) begin
      r_drain_cnt <= 1'b1;
    end else begin
      r_drain_cnt <= 1'b0;
    end
  end

  // Stage 1: control aligned with the read data returning from memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_acc   <= 1'b0;
      r_s1_relu  <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_o     <= '0;
    end else begin
      r_s1_valid <= w_issue;
      r_s1_acc   <= w_issue && (r_k != '0);
      r_s1_relu  <= w_issue && w_k_last && r_relu_mode;
      r_s1_last  <= w_issue && w_k_last;
      r_s1_o     <= r_o;
    end
  end

  // Stage 2: the SFP register now holds the finished pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_final_valid <= 1'b0;
      r_final_addr  <= '0;
    end else begin
      r_final_valid <= r_s1_last;
      r_final_addr  <= addr_bw'(r_s1_o);
    end
  end

  assign mem_rd_en   = w_issue;
  assign mem_addr    = r_addr;
  assign sfp_in      = mem_rdata;
  assign sfp_valid   = r_s1_valid;
  assign sfp_acc_en  = r_s1_acc;
  assign sfp_relu_en = r_s1_relu;
  assign final_valid = r_final_valid;
  assign final_addr  = r_final_addr;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_sfp_feeder.sv
// Bench for sfp_feeder: a queue-based pass model, a psum memory, and an
// SFP accumulator model, checked every cycle, plus hand-computed literals.
module tb_sfp_feeder;

  localparam int unsigned COL     = 8;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned NUM_O   = 2;
  localparam int unsigned NUM_KIJ = 3;
  localparam int unsigned ADDR_BW = 11;
  localparam int unsigned DATA_W  = COL * PSUM_BW;

  if (NUM_O * NUM_KIJ >= (2 ** ADDR_BW)) begin : g_addr_fit
    initial $fatal(1, "num_o*num_kij does not fit the address width");
  end

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               relu_mode = 1'b0;
  logic               hold = 1'b0;
  logic               mem_rd_en;
  logic [ADDR_BW-1:0] mem_addr;
  logic [DATA_W-1:0]  mem_rdata;
  logic [DATA_W-1:0]  sfp_in;
  logic               sfp_valid;
  logic               sfp_acc_en;
  logic               sfp_relu_en;
  logic               final_valid;
  logic [ADDR_BW-1:0] final_addr;
  logic               busy;
  logic               done;

  sfp_feeder #(
    .col(COL), .psum_bw(PSUM_BW), .num_o(NUM_O), .num_kij(NUM_KIJ), .addr_bw(ADDR_BW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .relu_mode(relu_mode), .hold(hold),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .sfp_in(sfp_in), .sfp_valid(sfp_valid), .sfp_acc_en(sfp_acc_en),
    .sfp_relu_en(sfp_relu_en), .final_valid(final_valid), .final_addr(final_addr),
    .busy(busy), .done(done)
  );

  // Psum memory, one-cycle read latency.
  logic [DATA_W-1:0] mem [64];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr[5:0]];

  function automatic int lane_of(logic [DATA_W-1:0] d, int j);
    return int'($signed(d[j*PSUM_BW +: PSUM_BW]));
  endfunction

  function automatic int lane(int a, int j);
    return lane_of(mem[6'(a)], j);
  endfunction

  // Expected pixel: sum of psums over all kij, optional ReLU at the end.
  function automatic int pixel(int o, int j, bit relu);
    int s = 0;
    for (int k = 0; k < int'(NUM_KIJ); k++) s += lane(k * int'(NUM_O) + o, j);
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  // SFP accumulator model driven by the DUT outputs.
  function automatic int sfp_step(int prev, int x, bit acc, bit relu);
    int s = acc ? prev + x : x;
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  int sfp_acc [COL];
  always @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < int'(COL); j++) sfp_acc[j] <= 0;
    end else if (sfp_valid) begin
      for (int j = 0; j < int'(COL); j++)
        sfp_acc[j] <= sfp_step(sfp_acc[j], lane_of(sfp_in, j), sfp_acc_en, sfp_relu_en);
    end
  end

  // Pass model: pending reads in issue order, then a 3-cycle tail.
  typedef struct { int addr; int o; int k; } rd_t;
  typedef struct { bit valid; bit acc; bit relu; bit last; int o; int addr; } s1_t;

  rd_t m_q[$];
  int  m_tail = 0;
  bit  m_relu = 0;
  s1_t m_s1 = '{default: 0};
  bit  m_fin_v = 0;
  int  m_fin_o = 0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic compare();
    bit e_busy = (m_q.size() > 0) || (m_tail > 0);
    bit e_done = (m_q.size() == 0) && (m_tail == 1);
    bit e_rd   = (m_q.size() > 0) && !hold;
    chk("busy", int'(busy), int'(e_busy));
    chk("done", int'(done), int'(e_done));
    chk("mem_rd_en", int'(mem_rd_en), int'(e_rd));
    if (e_rd && mem_rd_en) chk("mem_addr", int'(mem_addr), m_q[0].addr);
    if (!e_busy) chk("idle_mem_addr", int'(mem_addr), 0);
    chk("sfp_valid", int'(sfp_valid), int'(m_s1.valid));
    chk("sfp_acc_en", int'(sfp_acc_en), int'(m_s1.acc));
    chk("sfp_relu_en", int'(sfp_relu_en), int'(m_s1.relu));
    if (m_s1.valid && sfp_valid)
      for (int j = 0; j < int'(COL); j++) chk("sfp_in", lane_of(sfp_in, j), lane(m_s1.addr, j));
    chk("final_valid", int'(final_valid), int'(m_fin_v));
    if (m_fin_v && final_valid) begin
      chk("final_addr", int'(final_addr), m_fin_o);
      for (int j = 0; j < int'(COL); j++) chk("pixel", sfp_acc[j], pixel(m_fin_o, j, m_relu));
    end
  endtask

  task automatic model_edge(bit st, bit rl, bit hd, bit rs);
    s1_t n = '{default: 0};
    if (rs) begin
      m_q.delete();
      m_tail = 0; m_relu = 0; m_s1 = n; m_fin_v = 0; m_fin_o = 0;
      return;
    end
    m_fin_v = m_s1.last;
    m_fin_o = m_s1.o;
    if (m_q.size() > 0) begin
      if (!hd) begin
        n.valid = 1;
        n.acc   = (m_q[0].k != 0);
        n.last  = (m_q[0].k == int'(NUM_KIJ) - 1);
        n.relu  = n.last && m_relu;
        n.o     = m_q[0].o;
        n.addr  = m_q[0].addr;
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_tail = 3;
      end
    end else if (m_tail > 0) begin
      m_tail--;
    end else if (st) begin
      m_relu = rl;
      for (int o = 0; o < int'(NUM_O); o++)
        for (int k = 0; k < int'(NUM_KIJ); k++)
          m_q.push_back('{addr: k * int'(NUM_O) + o, o: o, k: k});
    end
    m_s1 = n;
  endtask

  // Per-scenario records for the literal checks.
  int addr_seq[$];
  int fin_cyc[$];
  int px_lane0[$];
  int done_cnt, done_cyc;
  int vtr[64], acc_tr[64], rel_tr[64], busy_tr[64];

  task automatic step(bit st, bit rl, bit hd, bit rs);
    @(posedge clk); #1;
    start = st; relu_mode = rl; hold = hd; reset = rs;
    @(negedge clk);
    compare();
    if (mem_rd_en) addr_seq.push_back(int'(mem_addr));
    if (final_valid) begin
      fin_cyc.push_back(cyc);
      px_lane0.push_back(sfp_acc[0]);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    vtr[cyc] = int'(sfp_valid); acc_tr[cyc] = int'(sfp_acc_en);
    rel_tr[cyc] = int'(sfp_relu_en); busy_tr[cyc] = int'(busy);
    model_edge(st, rl, hd, rs);
  endtask

  task automatic run(bit rl, int hold_lo, int hold_hi, int start_c, int start2, int rst_c, int ncyc);
    addr_seq.delete(); fin_cyc.delete(); px_lane0.delete();
    done_cnt = 0; done_cyc = -1;
    for (int c = 0; c < ncyc; c++) begin
      cyc = c;
      step((c == start_c) || (c == start2), rl, (c >= hold_lo) && (c <= hold_hi), c == rst_c);
    end
  endtask

  task automatic chk_addr_seq();
    int exp_addr[6] = '{0, 2, 4, 1, 3, 5};
    chk("addr_seq_len", addr_seq.size(), 6);
    for (int i = 0; i < 6 && i < addr_seq.size(); i++) chk("addr_seq", addr_seq[i], exp_addr[i]);
  endtask

  initial begin
    int exp_acc[6] = '{0, 1, 1, 0, 1, 1};
    int rel_cnt;
    for (int a = 0; a < 64; a++)
      for (int j = 0; j < int'(COL); j++)
        mem[a][j*PSUM_BW +: PSUM_BW] = PSUM_BW'(((a * 7 + j * 5) % 19) - 9);
    mem[0][PSUM_BW-1:0] = PSUM_BW'(-5);
    mem[2][PSUM_BW-1:0] = PSUM_BW'(2);
    mem[4][PSUM_BW-1:0] = PSUM_BW'(1);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    cyc = 0;
    step(0, 0, 0, 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_final_addr", int'(final_addr), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);

    // Basic pass with ReLU.
    run(1, -1, -1, 0, -1, -1, 12);
    chk_addr_seq();
    chk("a_fin_cnt", fin_cyc.size(), 2);
    if (fin_cyc.size() == 2) begin chk("a_fin0", fin_cyc[0], 5); chk("a_fin1", fin_cyc[1], 8); end
    chk("a_done_cyc", done_cyc, 9);
    chk("a_done_cnt", done_cnt, 1);
    for (int i = 0; i < 6; i++) chk("a_acc_tr", acc_tr[i + 2], exp_acc[i]);
    rel_cnt = 0;
    for (int i = 0; i < 12; i++) rel_cnt += rel_tr[i];
    chk("a_relu_cnt", rel_cnt, 2);
    chk("a_relu4", rel_tr[4], 1);
    chk("a_relu7", rel_tr[7], 1);
    if (px_lane0.size() > 0) chk("a_px0_relu", px_lane0[0], 0);

    // Same pass without ReLU: -5+2+1 = -2.
    run(0, -1, -1, 0, -1, -1, 12);
    chk_addr_seq();
    chk("b_done_cyc", done_cyc, 9);
    rel_cnt = 0;
    for (int i = 0; i < 12; i++) rel_cnt += rel_tr[i];
    chk("b_relu_cnt", rel_cnt, 0);
    chk("b_px_cnt", px_lane0.size(), 2);
    if (px_lane0.size() > 0) chk("b_px0", px_lane0[0], -2);

    // Hold during cycles 2-3.
    run(1, 2, 3, 0, -1, -1, 14);
    chk_addr_seq();
    chk("c_valid3", vtr[3], 0);
    chk("c_valid4", vtr[4], 0);
    chk("c_done_cyc", done_cyc, 11);
    chk("c_fin_cnt", fin_cyc.size(), 2);
    if (fin_cyc.size() == 2) begin chk("c_fin0", fin_cyc[0], 7); chk("c_fin1", fin_cyc[1], 10); end
    if (px_lane0.size() > 0) chk("c_px0_relu", px_lane0[0], 0);

    // Second start while busy is ignored.
    run(0, -1, -1, 0, 3, -1, 14);
    chk("d_done_cnt", done_cnt, 1);
    chk("d_fin_cnt", fin_cyc.size(), 2);
    chk("d_done_cyc", done_cyc, 9);

    // Reset mid-pass, then a fresh pass starting at cycle 7.
    run(1, -1, -1, 0, 7, 4, 19);
    chk("e_busy5", busy_tr[5], 0);
    chk("e_valid5", vtr[5], 0);
    chk("e_done_cnt", done_cnt, 1);
    chk("e_done_cyc", done_cyc, 16);
    chk("e_fin_cnt", fin_cyc.size(), 2);
    if (fin_cyc.size() == 2) begin chk("e_fin0", fin_cyc[0], 12); chk("e_fin1", fin_cyc[1], 15); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfp_feeder.md
SFP_FEEDER -- requirements
Module: sfp_feeder

Interface
REQ-001 Parameters, one per line:
- col, 8, number of psum columns per memory word.
- psum_bw, 16, bits per psum lane.
- num_o, 16, output pixels per pass.
- num_kij, 9, kernel positions accumulated per output pixel.
- addr_bw, 11, psum memory address width.

REQ-002 Clock and reset: reset is synchronous and active-high; the clock is clk.

REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, begin one pass; sampled in IDLE only.
- relu_mode, in, 1, apply ReLU on the final kij; sampled with start.
- hold, in, 1, stall read issue.
- mem_rd_en, out, 1, psum memory read strobe.
- mem_addr, out, addr_bw, psum memory read address.
- mem_rdata, in, psum_bw*col, read data; valid 1 cycle after mem_rd_en.
- sfp_in, out, psum_bw*col, data to the SFP.
- sfp_valid, out, 1, SFP valid_in.
- sfp_acc_en, out, 1, SFP accumulate enable.
- sfp_relu_en, out, 1, SFP ReLU enable.
- final_valid, out, 1, SFP output holds the finished pixel this cycle.
- final_addr, out, addr_bw, index of that pixel.
- busy, out, 1, pass in progress.
- done, out, 1, one-cycle pass-complete pulse.

Function
REQ-004 FSM states: IDLE, READ, DRAIN, DONE.
REQ-005 IDLE -> READ on the edge where start=1; relu_mode is latched on that edge; the counters o=0 and k=0 are cleared.
REQ-006 READ with hold=0:
- mem_rd_en=1 and mem_addr=k*num_o+o (kij-major psum layout).
- Then k increments; when k=num_kij-1, k wraps to 0 and o increments.
REQ-007 READ with hold=1: mem_rd_en=0 and the counters are frozen; the downstream pipeline still advances and inserts a bubble.
REQ-008 READ -> DRAIN after issuing the read for o=num_o-1, k=num_kij-1.
REQ-009 Stage-1 registers (one cycle after issue):
- sfp_valid = delayed mem_rd_en.
- sfp_acc_en = delayed (k!=0).
- sfp_relu_en = delayed (k==num_kij-1 && relu_mode_latched).
- sfp_in = mem_rdata, driven combinationally and aligned with sfp_valid.
REQ-010 Stage 2: final_valid=1 exactly one cycle after a stage-1 beat with k==num_kij-1; final_addr = the o of that beat.
REQ-011 DRAIN lasts exactly 2 cycles. It then moves to DONE, which lasts 1 cycle with done=1, then returns to IDLE.
REQ-012 busy=1 in READ, DRAIN and DONE; busy=0 in IDLE.
REQ-013 start is ignored while busy=1.
REQ-014 Address arithmetic is unsigned and truncated to addr_bw bits. The product num_o*num_kij must fit in addr_bw bits; the bench checks this with an elaboration check.
REQ-015 sfp_acc_en and sfp_relu_en are 0 whenever sfp_valid=0.
REQ-016 sfp_in is don't-care when sfp_valid=0.
REQ-017 With no hold, the pass takes num_o*num_kij READ cycles + 2 DRAIN cycles + 1 DONE cycle.
REQ-018 The first kij of each pixel (k=0) always restarts accumulation (acc_en=0), including the first beat after a hold.

Reset
REQ-019 reset=1 forces the following on the next edge, from any state including mid-pass:
- State returns to IDLE and all counters clear.
- relu_mode_latched=0.
- The outputs mem_rd_en, sfp_valid, sfp_acc_en, sfp_relu_en, final_valid, busy and done all go to 0.
- mem_addr=0 and final_addr=0.
REQ-020 In-flight reads are discarded on reset; no final_valid is produced for a partially accumulated pixel.

Verification (bench uses num_o=2, num_kij=3)
REQ-021 Basic pass: start=1 at cycle 0, relu_mode=1, hold=0 ->
- mem_addr = 0,2,4,1,3,5 in cycles 1-6.
- sfp_acc_en = 0,1,1,0,1,1 in cycles 2-7.
- sfp_relu_en=1 in cycles 4 and 7 only.
- final_valid in cycle 5 (addr 0) and cycle 8 (addr 1).
- done in cycle 9.
REQ-022 relu_mode=0 pass: identical timing to REQ-021 with sfp_relu_en=0 throughout. With the SFP model attached, psums -5,2,1 give final output -2; with relu_mode=1 the output is 0.
REQ-023 hold=1 during cycles 2-3 of REQ-021:
- mem_addr sequence 0, (stall), (stall), 2, 4, 1, 3, 5.
- sfp_valid=0 in cycles 3-4.
- Accumulated results are unchanged.
- done moves later by 2 cycles, to cycle 11.
REQ-024 start pulsed at cycles 0 and 3 -> the second start is ignored; exactly one done pulse and 2 final_valid pulses.
REQ-025 reset=1 in cycle 4 of a pass -> from cycle 5 all outputs are 0 and busy=0; no final_valid or done follows. A new start at cycle 7 runs a full pass with the REQ-021 timing offset by 7.
